// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - shared UART definitions: arbiter state encoding and requester limit
package uart_defs;

    // Transmit arbiter states: IDLE (no owner) and LOCK (owner holds the path for a packet)
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } ArbState_t;

    // Largest requester count the arbiter and picker are built for
    localparam int UART_ARB_MAXREQ = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker
//  Purpose: choose the first set bit of req_i at or after ptr_i, wrapping N-1 -> 0.
//  Ports:
//   req_i  in  N   request vector
//   ptr_i  in  IW  starting index of the search (must be < N)
//   gnt_o  out N   one-hot winner, 0 when no request
//   idx_o  out IW  binary index of the winner, 0 when no request
//   any_o  out 1   at least one request present
module uart_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic          found;
    logic [IW-1:0] j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter for the UART TX byte path
//  Purpose: share the single TX FIFO write port between NREQ byte-stream requesters.
//   The winner owns the path until it sends a byte flagged last or stalls for TIMEOUT cycles.
//  Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   enable_i                   allow new grants (current packet always finishes)
//   req_valid_i/data_i/last_i  per-requester byte stream, data packed [i*8 +: 8]
//   req_ready_o                per-requester accept (combinational)
//   tx_d_o, tx_d_valid_o       registered byte and one-cycle write strobe to TX FIFO
//   tx_full_i                  TX FIFO full, one cycle stale
//   grant_o, busy_o            one-hot owner, state != IDLE
//   timeout_o                  one-cycle pulse on forced release
module uart_tx_arbiter
    import uart_defs::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [NREQ*8-1:0] req_data_i,
    input  logic [NREQ-1:0]   req_last_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic [7:0]        tx_d_o,
    output logic              tx_d_valid_o,
    input  logic              tx_full_i,
    output logic [NREQ-1:0]   grant_o,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_EXP = CW'(TIMEOUT - 1);

    ArbState_t       state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   nxt_ptr;
    logic [CW-1:0]   stall_cnt;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            accept;
    logic            stall_expire;
    logic [7:0]      gdata;

    uart_rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Blocking accept while the previous strobe is out gives the FIFO's stale full
    // flag one cycle to catch up, so at most one byte lands every two clocks.
    assign accept       = (state == ARB_LOCK) && req_valid_i[gidx] && !tx_full_i && !tx_d_valid_o;
    assign req_ready_o  = accept ? grant_o : '0;
    assign gdata        = req_data_i[{gidx, 3'b000} +: 8];
    assign nxt_ptr      = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
    assign stall_expire = (state == ARB_LOCK) && !accept && (stall_cnt == CNT_EXP);
    assign busy_o       = (state != ARB_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ARB_IDLE;
            rr_ptr       <= '0;
            gidx         <= '0;
            grant_o      <= '0;
            tx_d_o       <= '0;
            tx_d_valid_o <= 1'b0;
            timeout_o    <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            tx_d_valid_o <= accept;
            timeout_o    <= 1'b0;
            if (accept) begin
                tx_d_o <= gdata;
            end

            if (state == ARB_IDLE) begin
                stall_cnt <= '0;
                if (enable_i && pick_any) begin
                    grant_o <= pick_gnt;
                    gidx    <= pick_idx;
                    state   <= ARB_LOCK;
                end
            end else begin
                // Accept takes priority over an expiring counter on the same cycle.
                if (accept) begin
                    stall_cnt <= '0;
                    if (req_last_i[gidx]) begin
                        state   <= ARB_IDLE;
                        grant_o <= '0;
                        rr_ptr  <= nxt_ptr;
                    end
                end else if (stall_expire) begin
                    state     <= ARB_IDLE;
                    grant_o   <= '0;
                    rr_ptr    <= nxt_ptr;
                    timeout_o <= 1'b1;
                    stall_cnt <= '0;
                end else if (!tx_full_i && (stall_cnt != CNT_MAX)) begin
                    // A full FIFO is back-pressure, not a stalled requester: hold.
                    stall_cnt <= stall_cnt + CW'(1);
                end
            end
        end
    end

endmodule
